memory_access_hs: RTL
=====================

Name: memory_access_hs

Overview:
Parametrised, handshaked RV32I/RV64I memory-access (MA) pipeline stage. It sits between the EX/MA boundary and the MA/WB register.
- Issues one data-memory transaction per load/store over a req/gnt + rvalid bus that may take multiple cycles.
- Generates byte enables and lane-shifted store data.
- Aligns and extends load data.
- Flags misaligned accesses.
- Stalls EX while a transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with MA_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  global enable; when 0, all state holds.
- i_ex_valid  in  1  EX presents an instruction.
- i_ex_mem_to_reg  in  1  pass-through control.
- i_ex_rw_sel  in  1  pass-through control.
- i_ex_reg_wr  in  1  register write enable.
- i_ex_mem_rd  in  1  load.
- i_ex_mem_wr  in  1  store.
- i_ex_pc_plus_4  in  XLEN  pass-through.
- i_ex_alu_result  in  XLEN  effective address / ALU result.
- i_ex_reg_read_data2  in  XLEN  store data.
- i_ex_reg_dest  in  5  destination register.
- i_ex_funct3  in  3  access size/sign.
- o_ex_stall  out  1  EX must hold its inputs.
- o_dmem_req  out  1  bus request.
- i_dmem_gnt  in  1  request accepted.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  ADDR_W  address aligned to XLEN/8 bytes.
- o_dmem_be  out  XLEN/8  byte enables.
- o_dmem_wdata  out  XLEN  lane-shifted store data.
- i_dmem_rvalid  in  1  response valid (loads and stores).
- i_dmem_rdata  in  XLEN  read data.
- o_ma_valid  out  1  MA/WB register holds an instruction.
- o_ma_mem_to_reg, o_ma_rw_sel, o_ma_reg_wr  out  1  registered controls.
- o_ma_pc_plus_4, o_ma_result, o_ma_read_data  out  XLEN  registered data.
- o_ma_reg_dest  out  5  registered destination.
- o_ma_misalign  out  1  registered misaligned-access flag.

Behaviour:
- Reset: synchronous on rst=1 at a clk edge, regardless of clk_en.
  - All o_ma_* outputs, o_dmem_* outputs and o_ex_stall go to 0.
  - FSM goes to IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, i_ex_valid=1, mem op, aligned: capture the request (addr, be, wdata, funct3, controls) and go to REQ. o_ex_stall=1 combinationally in that same cycle.
- REQ: o_dmem_req=1; address, be, we and wdata are stable until gnt. gnt=1 goes to WAIT; rvalid in the same cycle as gnt is legal and goes straight to the completion path.
- WAIT: o_dmem_req=0 and o_ex_stall=1. rvalid=1 completes the access: the MA/WB register is written (o_ma_valid=1), stall is released, and the FSM returns to IDLE.
- Bus latency: minimum 1 cycle req→done (gnt and rvalid in the same cycle as req). EX sees exactly (bus latency) stall cycles.
- Non-memory instruction: MA/WB register written on the next edge with o_ma_read_data=0. No stall, no bus activity.
- Address alignment:
  - Size = 1 << funct3[1:0].
  - Misaligned when addr mod size ≠ 0.
  - funct3 011/110 are legal only when XLEN=64; otherwise they are treated as misaligned.
- Misaligned access:
  - No bus transaction, no stall.
  - MA/WB is written next cycle with o_ma_misalign=1 and o_ma_reg_wr forced to 0.
- Byte enables: size-wide mask shifted left by addr[log2(XLEN/8)-1:0]. wdata is rs2 replicated/shifted into the same lanes.
- Load data: rdata is shifted right by byte offset, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) from the access size. Word access with XLEN=32 is passed through unchanged.
- clk_en=0: FSM, captured request and MA/WB register all hold. o_dmem_req holds its value. gnt/rvalid arriving while clk_en=0 are the bus's responsibility to hold.
- Reset mid-transaction: FSM returns to IDLE, the outstanding response is discarded and no MA/WB write occurs.
- i_ex_mem_rd and i_ex_mem_wr both 1: treated as a store.

Optional Feature:
MA_TIMEOUT_EN:
- Defined: a counter runs in REQ/WAIT and clears on entry to REQ. When it reaches TIMEOUT_CYC, the FSM returns to IDLE, MA/WB is written with o_ma_misalign=1 and o_ma_reg_wr=0, and the stall is released. A late rvalid after that point is ignored.
- Undefined: the FSM waits indefinitely, and no counter logic exists.

Test Plan:
1. XLEN=32, LB at addr 0x13, rdata 0x80xxxxxx, gnt+rvalid same cycle as req → be=4'b1000, o_ma_read_data=0xFFFFFF80, 1 stall cycle.
2. LHU at addr 0x12, rdata 0xABCD0000, rvalid 3 cycles after gnt → o_ma_read_data=0x0000ABCD, o_ex_stall high for 4 cycles.
3. SW 0xCAFEBABE at 0x10000000 → we=1, be=4'hF, wdata=0xCAFEBABE, addr=0x10000000, o_ma_reg_wr=0.
4. SH at addr 0x11 → no req, no stall, next cycle o_ma_misalign=1, o_ma_reg_wr=0.
5. rst asserted while in WAIT, then rvalid → FSM IDLE, o_ma_valid stays 0; clk_en=0 for 2 cycles during REQ → o_dmem_req and addr held.
6. MA_TIMEOUT_EN, TIMEOUT_CYC=8, gnt never asserted → stall released after 8 cycles, o_ma_misalign=1.

Source files
------------

// File: rtl/memory_access_hs.sv
// Handshaked RV32I/RV64I memory-access stage: req/gnt + rvalid data bus, lane steering, load extension.
// Optional build macro MA_TIMEOUT_EN adds a watchdog that abandons a stuck transaction after TIMEOUT_CYC cycles.
module memory_access_hs #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                i_ex_valid,
    input  logic                i_ex_mem_to_reg,
    input  logic                i_ex_rw_sel,
    input  logic                i_ex_reg_wr,
    input  logic                i_ex_mem_rd,
    input  logic                i_ex_mem_wr,
    input  logic [XLEN-1:0]     i_ex_pc_plus_4,
    input  logic [XLEN-1:0]     i_ex_alu_result,
    input  logic [XLEN-1:0]     i_ex_reg_read_data2,
    input  logic [4:0]          i_ex_reg_dest,
    input  logic [2:0]          i_ex_funct3,
    output logic                o_ex_stall,
    output logic                o_dmem_req,
    input  logic                i_dmem_gnt,
    output logic                o_dmem_we,
    output logic [ADDR_W-1:0]   o_dmem_addr,
    output logic [XLEN/8-1:0]   o_dmem_be,
    output logic [XLEN-1:0]     o_dmem_wdata,
    input  logic                i_dmem_rvalid,
    input  logic [XLEN-1:0]     i_dmem_rdata,
    output logic                o_ma_valid,
    output logic                o_ma_mem_to_reg,
    output logic                o_ma_rw_sel,
    output logic                o_ma_reg_wr,
    output logic [XLEN-1:0]     o_ma_pc_plus_4,
    output logic [XLEN-1:0]     o_ma_result,
    output logic [XLEN-1:0]     o_ma_read_data,
    output logic [4:0]          o_ma_reg_dest,
    output logic                o_ma_misalign
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state;
    logic                mem_op;
    logic                is_store;
    logic                aligned;
    logic                start;
    logic                done;
    logic                timeout_hit;
    logic [OFF_W-1:0]    ex_off;
    logic [ADDR_W-1:0]   ex_addr;
    logic [BE_W-1:0]     size_mask;
    logic [BE_W-1:0]     ex_be;
    logic [XLEN-1:0]     ex_wdata;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     load_data;

    logic [OFF_W-1:0]    req_off;
    logic [2:0]          req_funct3;
    logic                req_mem_to_reg;
    logic                req_rw_sel;
    logic                req_reg_wr;
    logic [XLEN-1:0]     req_pc_plus_4;
    logic [XLEN-1:0]     req_result;
    logic [4:0]          req_dest;

    // A set store bit wins when both read and write are flagged.
    assign mem_op   = i_ex_mem_rd | i_ex_mem_wr;
    assign is_store = i_ex_mem_wr;
    assign ex_addr  = ADDR_W'(i_ex_alu_result);
    assign ex_off   = i_ex_alu_result[OFF_W-1:0];

    always_comb begin
        size_mask = BE_W'(1);
        aligned   = 1'b1;
        case (i_ex_funct3[1:0])
            2'b00: begin
                size_mask = BE_W'(1);
                aligned   = 1'b1;
            end
            2'b01: begin
                size_mask = BE_W'(3);
                aligned   = ~ex_off[0];
            end
            2'b10: begin
                size_mask = BE_W'(15);
                aligned   = (ex_off[1:0] == 2'b00);
            end
            default: begin
                size_mask = '1;
                aligned   = (XLEN == 64) && (ex_off == '0);
            end
        endcase
        // Unsigned word loads only exist on RV64.
        if ((XLEN == 32) && (i_ex_funct3 == 3'b110)) begin
            aligned = 1'b0;
        end
    end

    assign ex_be    = size_mask << ex_off;
    assign ex_wdata = i_ex_reg_read_data2 << {ex_off, 3'b000};
    assign start    = i_ex_valid & mem_op & aligned;

    always_comb begin
        done = 1'b0;
        case (state)
            REQ:     done = i_dmem_gnt & i_dmem_rvalid;
            WAIT:    done = i_dmem_rvalid;
            default: done = 1'b0;
        endcase
    end

    // Stall drops in the cycle the access finishes so EX sees exactly the bus latency.
    assign o_ex_stall = (state == IDLE) ? start : ~(clk_en & (done | timeout_hit));

    assign shifted = i_dmem_rdata >> {req_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (req_funct3[1:0])
            2'b00: begin
                if (req_funct3[2]) load_data = XLEN'(shifted[7:0]);
                else               load_data = XLEN'($signed(shifted[7:0]));
            end
            2'b01: begin
                if (req_funct3[2]) load_data = XLEN'(shifted[15:0]);
                else               load_data = XLEN'($signed(shifted[15:0]));
            end
            2'b10: begin
                if (req_funct3[2]) load_data = XLEN'(shifted[31:0]);
                else               load_data = XLEN'($signed(shifted[31:0]));
            end
            default: load_data = shifted;
        endcase
    end

`ifdef MA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_count;

    // A real response in the final cycle still takes priority over the watchdog.
    assign timeout_hit = (state != IDLE) && (to_count == CNT_W'(TIMEOUT_CYC - 1)) && ~done;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_count <= '0;
        end else if (clk_en) begin
            if (state == IDLE) begin
                to_count <= '0;
            end else begin
                to_count <= to_count + 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            o_dmem_req      <= 1'b0;
            o_dmem_we       <= 1'b0;
            o_dmem_addr     <= '0;
            o_dmem_be       <= '0;
            o_dmem_wdata    <= '0;
            req_off         <= '0;
            req_funct3      <= '0;
            req_mem_to_reg  <= 1'b0;
            req_rw_sel      <= 1'b0;
            req_reg_wr      <= 1'b0;
            req_pc_plus_4   <= '0;
            req_result      <= '0;
            req_dest        <= '0;
            o_ma_valid      <= 1'b0;
            o_ma_mem_to_reg <= 1'b0;
            o_ma_rw_sel     <= 1'b0;
            o_ma_reg_wr     <= 1'b0;
            o_ma_pc_plus_4  <= '0;
            o_ma_result     <= '0;
            o_ma_read_data  <= '0;
            o_ma_reg_dest   <= '0;
            o_ma_misalign   <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= REQ;
                        o_dmem_req     <= 1'b1;
                        o_dmem_we      <= is_store;
                        o_dmem_addr    <= ex_addr & ~ADDR_W'(BE_W - 1);
                        o_dmem_be      <= ex_be;
                        o_dmem_wdata   <= is_store ? ex_wdata : '0;
                        req_off        <= ex_off;
                        req_funct3     <= i_ex_funct3;
                        req_mem_to_reg <= i_ex_mem_to_reg;
                        req_rw_sel     <= i_ex_rw_sel;
                        req_reg_wr     <= i_ex_reg_wr;
                        req_pc_plus_4  <= i_ex_pc_plus_4;
                        req_result     <= i_ex_alu_result;
                        req_dest       <= i_ex_reg_dest;
                        o_ma_valid     <= 1'b0;
                    end else if (i_ex_valid) begin
                        // Either a non-memory op or a misaligned access; neither touches the bus.
                        o_ma_valid      <= 1'b1;
                        o_ma_mem_to_reg <= i_ex_mem_to_reg;
                        o_ma_rw_sel     <= i_ex_rw_sel;
                        o_ma_reg_wr     <= i_ex_reg_wr & ~mem_op;
                        o_ma_pc_plus_4  <= i_ex_pc_plus_4;
                        o_ma_result     <= i_ex_alu_result;
                        o_ma_read_data  <= '0;
                        o_ma_reg_dest   <= i_ex_reg_dest;
                        o_ma_misalign   <= mem_op;
                    end else begin
                        o_ma_valid <= 1'b0;
                    end
                end
                REQ, WAIT: begin
                    if (done || timeout_hit) begin
                        state           <= IDLE;
                        o_dmem_req      <= 1'b0;
                        o_ma_valid      <= 1'b1;
                        o_ma_mem_to_reg <= req_mem_to_reg;
                        o_ma_rw_sel     <= req_rw_sel;
                        o_ma_reg_wr     <= req_reg_wr & done;
                        o_ma_pc_plus_4  <= req_pc_plus_4;
                        o_ma_result     <= req_result;
                        o_ma_read_data  <= (done && !o_dmem_we) ? load_data : '0;
                        o_ma_reg_dest   <= req_dest;
                        o_ma_misalign   <= ~done;
                    end else begin
                        o_ma_valid <= 1'b0;
                        if ((state == REQ) && i_dmem_gnt) begin
                            o_dmem_req <= 1'b0;
                            state      <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
